// File: rtl/ifft_bitrev_reorder_pkg.sv
// Shared definitions for the IFFT output reorder stage: default frame
// geometry (common with the FFT/IFFT blocks), read FSM states and the
// index helper functions.
package ifft_bitrev_reorder_pkg;

  localparam int DEFAULT_N     = 64;
  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE,
    READ
  } rd_state_t;

  // Smallest exponent e with 2**e >= value; sizes the bank address.
  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Mirror the low 'bits' bits of index (bit i moves to bit bits-1-i).
  function automatic int unsigned bitrev(input int unsigned index, input int bits);
    int unsigned result;
    result = 0;
    for (int i = 0; i < bits; i++) begin
      result[bits-1-i] = index[i];
    end
    return result;
  endfunction

endpackage

// File: rtl/ifft_bitrev_reorder_bank_ram.sv
// One N-entry sample bank of the reorder ping-pong memory. Writes are
// synchronous; the read port is registered and returns zero whenever the
// bank is not selected, so the two banks can simply be OR-ed together.
module reorder_bank_ram
  import ifft_bitrev_reorder_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int DATA_W = 2 * DEFAULT_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [log2_ceil(N)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  input  logic [log2_ceil(N)-1:0]   rd_addr,
  output logic [DATA_W-1:0]         rd_data
);

  logic [DATA_W-1:0] mem [N];

  // Storage is never cleared: every entry is rewritten before it is read.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered, bank-select-gated read port.
  always_ff @(posedge clock) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end

endmodule

// File: rtl/ifft_bitrev_reorder.sv
// Reorders bit-reversed SDF IFFT frames into natural time order using a
// ping-pong pair of banks, emitting each frame as a gap-free N-sample burst
// starting the cycle after the frame's last input sample.
// Optional feature macro: IFFT_REORDER_SOF_EN adds the data_out_sof port.
module ifft_bitrev_reorder
  import ifft_bitrev_reorder_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_in_en,
  input  logic [WIDTH-1:0] data_in_real,
  input  logic [WIDTH-1:0] data_in_imag,
  output logic             data_out_en,
  output logic [WIDTH-1:0] data_out_real,
  output logic [WIDTH-1:0] data_out_imag
`ifdef IFFT_REORDER_SOF_EN
  ,
  output logic             data_out_sof
`endif
);

  localparam int AW = log2_ceil(N);
  localparam int DW = 2 * WIDTH;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  rd_state_t     state;
  rd_state_t     next_state;
  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          frame_done;
  logic          read_advance;
  logic [1:0]    bank_wr_en;
  logic [1:0]    bank_rd_en;
  logic [DW-1:0] bank_rd_data [2];
  logic [DW-1:0] read_word;

  // The output register is loaded one step ahead of rd_cnt: on the frame
  // completion edge entry 0 of the finished bank is fetched, and while
  // emitting index rd_cnt the next index is fetched.
  assign frame_done   = data_in_en && (wr_cnt == LAST);
  assign read_advance = (state == READ) && (rd_cnt != LAST);
  assign wr_addr      = AW'(bitrev(32'(wr_cnt), AW));
  assign rd_addr      = frame_done ? '0 : AW'(rd_cnt + 1'b1);

  // Steer writes to the filling bank and reads to the draining bank.
  always_comb begin
    bank_wr_en = 2'b00;
    bank_rd_en = 2'b00;
    if (data_in_en) bank_wr_en[wr_bank] = 1'b1;
    if (frame_done)        bank_rd_en[wr_bank] = 1'b1;
    else if (read_advance) bank_rd_en[rd_bank] = 1'b1;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank_ram #(
      .N      (N),
      .DATA_W (DW)
    ) u_bank (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (bank_wr_en[b]),
      .wr_addr (wr_addr),
      .wr_data ({data_in_real, data_in_imag}),
      .rd_en   (bank_rd_en[b]),
      .rd_addr (rd_addr),
      .rd_data (bank_rd_data[b])
    );
  end

  // Write/read counters and bank pointers; a completed frame hands its bank to the reader.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (data_in_en) wr_cnt <= wr_cnt + 1'b1;
      if (frame_done) begin
        wr_bank <= ~wr_bank;
        rd_bank <= wr_bank;
        rd_cnt  <= '0;
      end else if (state == READ) begin
        rd_cnt  <= rd_cnt + 1'b1;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Read FSM transitions: a frame arriving on the last read index restarts the burst seamlessly.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frame_done) next_state = READ;
      READ:    if ((rd_cnt == LAST) && !frame_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: the unselected bank reads zero, so idle cycles drive zero data.
  always_comb begin
    read_word     = bank_rd_data[0] | bank_rd_data[1];
    data_out_en   = (state == READ);
    data_out_real = read_word[DW-1:WIDTH];
    data_out_imag = read_word[WIDTH-1:0];
  end

`ifdef IFFT_REORDER_SOF_EN
  // Start-of-frame flag registered together with the fetch of natural index 0.
  always_ff @(posedge clock) begin
    if (reset) data_out_sof <= 1'b0;
    else       data_out_sof <= frame_done;
  end
`endif

`ifndef SYNTHESIS
  // A frame can only complete while the reader is on its final index.
  always_ff @(posedge clock) begin
    if (!reset) assert (!(frame_done && (state == READ) && (rd_cnt != LAST)));
  end
`endif

endmodule

// File: tb/tb_ifft_bitrev_reorder.sv
// Testbench for ifft_bitrev_reorder: an N=8 and an N=64 instance share one
// input stream; a frame-level reference model predicts every output cycle.
// Honours IFFT_REORDER_SOF_EN for the data_out_sof checks.
module tb_ifft_bitrev_reorder;

  logic        clock;
  logic        reset;
  logic        din_en;
  logic [15:0] din_re;
  logic [15:0] din_im;

  logic        en8, en64;
  logic [15:0] re8, im8, re64, im64;
  logic        sof8, sof64;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = N8 instance, 1 = N64 instance.
  int          frame_len [2] = '{8, 64};
  int          frame_bits [2] = '{3, 6};
  int          fill [2] = '{0, 0};
  logic [31:0] frame_buf [2][64];
  logic [32:0] exp_map [int];

  ifft_bitrev_reorder #(.N(8), .WIDTH(16)) u_dut8 (
    .clock         (clock),
    .reset         (reset),
    .data_in_en    (din_en),
    .data_in_real  (din_re),
    .data_in_imag  (din_im),
    .data_out_en   (en8),
    .data_out_real (re8),
    .data_out_imag (im8)
`ifdef IFFT_REORDER_SOF_EN
    ,
    .data_out_sof  (sof8)
`endif
  );

  ifft_bitrev_reorder #(.N(64), .WIDTH(16)) u_dut64 (
    .clock         (clock),
    .reset         (reset),
    .data_in_en    (din_en),
    .data_in_real  (din_re),
    .data_in_imag  (din_im),
    .data_out_en   (en64),
    .data_out_real (re64),
    .data_out_imag (im64)
`ifdef IFFT_REORDER_SOF_EN
    ,
    .data_out_sof  (sof64)
`endif
  );

`ifndef IFFT_REORDER_SOF_EN
  assign sof8  = 1'b0;
  assign sof64 = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int ref_bitrev(input int value, input int bits);
    int r;
    int v;
    r = 0;
    v = value;
    repeat (bits) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, actual, expected);
    end
  endtask

  task automatic checkDut(input int d, input logic en, input logic [15:0] re,
                          input logic [15:0] im, input logic sof);
    int          key;
    logic        exp_en;
    logic [32:0] e;
    key    = d * 1000000 + cyc;
    exp_en = exp_map.exists(key);
    e      = exp_en ? exp_map[key] : 33'd0;
    checkOutput($sformatf("en_n%0d", frame_len[d]), {31'd0, en}, {31'd0, exp_en});
    checkOutput($sformatf("real_n%0d", frame_len[d]), {16'd0, re}, {16'd0, e[31:16]});
    checkOutput($sformatf("imag_n%0d", frame_len[d]), {16'd0, im}, {16'd0, e[15:0]});
`ifdef IFFT_REORDER_SOF_EN
    checkOutput($sformatf("sof_n%0d", frame_len[d]), {31'd0, sof}, {31'd0, e[32]});
`else
    if (sof !== 1'b0) checkOutput("sof_tie", {31'd0, sof}, 32'd0);
`endif
    if (exp_en) exp_map.delete(key);
  endtask

  // One cycle: check what the DUTs show now, then present the next input
  // and let the model account for the edge that will accept it.
  task automatic applyStimulus(input logic en, input logic [15:0] re,
                               input logic [15:0] im, input logic rst);
    int edge_no;
    @(negedge clock);
    checkDut(0, en8, re8, im8, sof8);
    checkDut(1, en64, re64, im64, sof64);
    reset  = rst;
    din_en = en;
    din_re = re;
    din_im = im;
    edge_no = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        fill[d] = 0;
        for (int c = edge_no; c < edge_no + 70; c++) begin
          if (exp_map.exists(d * 1000000 + c)) exp_map.delete(d * 1000000 + c);
        end
      end else if (en) begin
        frame_buf[d][fill[d]] = {re, im};
        fill[d]++;
        if (fill[d] == frame_len[d]) begin
          for (int k = 0; k < frame_len[d]; k++) begin
            exp_map[d * 1000000 + edge_no + k] =
              {(k == 0), frame_buf[d][ref_bitrev(k, frame_bits[d])]};
          end
          fill[d] = 0;
        end
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 16'd0, 16'd0, 1'b0);
  endtask

  task automatic resetCycles(input int n);
    repeat (n) applyStimulus(1'b0, 16'd0, 16'd0, 1'b1);
  endtask

  initial begin
    int br;
    reset  = 1'b1;
    din_en = 1'b0;
    din_re = '0;
    din_im = '0;

    resetCycles(3);
    idleCycles(2);

    // Directed frame: bit-reversed ramp comes out as a natural ramp.
    for (int j = 0; j < 8; j++) begin
      br = ref_bitrev(j, 3);
      applyStimulus(1'b1, 16'(br), 16'(-br), 1'b0);
    end
    idleCycles(12);

    // Three back-to-back frames with offsets 0, 100, 200.
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 8; j++) begin
        br = ref_bitrev(j, 3);
        applyStimulus(1'b1, 16'(f * 100 + br), 16'(1000 + f * 100 + br), 1'b0);
      end
    end
    idleCycles(12);

    // One idle cycle after every input sample.
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0);
      idleCycles(1);
    end
    idleCycles(12);

    // Full-scale extremes must pass bit-exact.
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b1, j[0] ? 16'h8000 : 16'h7FFF, j[0] ? 16'h7FFF : 16'h8000, 1'b0);
    end
    idleCycles(12);

    // Reset after 30 inputs (N=8 instance is mid-burst), then clean frames.
    resetCycles(2);
    for (int j = 0; j < 30; j++) applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0);
    resetCycles(2);
    for (int j = 0; j < 128; j++) applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0);
    idleCycles(70);

    // Random gaps and values.
    for (int j = 0; j < 400; j++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'b0);
    end
    idleCycles(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
